// File: rtl/prog_mem.sv
// Program memory: default image on reset, reloadable word-by-word; optional CHK via PROG_MEM_CHECKSUM_EN.
// Latency: fetch is combinational; init takes DEPTH cycles; LD_DONE follows the last accepted word by one cycle.
// Backpressure: ld_ready is high only in LOAD; words offered outside LOAD or with ld_start are dropped.
module prog_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
`ifdef PROG_MEM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              ld_acc;
    logic              wr_en;
    logic [DATA_W-1:0] wr_dat;

    function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
        int unsigned idx;
        logic [7:0]  w;
        idx = 32'(a);
        case (idx)
            0:       w = 8'hB3;
            1:       w = 8'hB6;
            2:       w = 8'hBC;
            3:       w = 8'hB8;
            4:       w = 8'hB8;
            5:       w = 8'hBC;
            6:       w = 8'hB6;
            7:       w = 8'hB3;
            8:       w = 8'hB1;
            9:       w = 8'hF0;
            default: w = 8'h00;
        endcase
        return DATA_W'(w);
    endfunction

    // A word offered together with ld_start belongs to the abandoned load.
    always_comb begin
        ld_acc = (state == LOAD) && ld_valid && !ld_start;
        wr_en  = (state == INIT) || ld_acc;
        wr_dat = (state == INIT) ? default_word(ptr) : ld_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= wr_dat;
        end
    end

    assign data = busy ? '0 : mem[addr];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= INIT;
            ptr      <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            busy     <= 1'b1;
        end else begin
            ld_done <= 1'b0;
            case (state)
                INIT: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        ptr <= '0;
                    end else if (ld_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr == LAST) begin
                            state    <= IDLE;
                            ptr      <= '0;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= INIT;
                    ptr      <= '0;
                    ld_ready <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            chk <= '0;
        end else if (ld_start && (state != INIT)) begin
            chk <= '0;
        end else if (ld_acc) begin
            chk <= chk + ld_data;
        end
    end
`endif

endmodule
